// File: rtl/npc_pkg.sv
// Shared types and constants for the next-PC sequencer.
// The optional alignment check is enabled by defining ALIGN_CHECK_EN.
package npc_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  localparam logic [XLEN-1:0] RESET_PC_DFLT   = 32'h0040_0000;
  localparam logic [XLEN-1:0] EXC_VECTOR_DFLT = 32'h0040_0004;

  typedef logic [1:0] state_t;
  localparam state_t ST_BOOT  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_STALL = 2'd2;

  // Redirect source priority; a larger value wins.
  typedef logic [2:0] pri_t;
  localparam pri_t PRI_NONE = 3'd0;
  localparam pri_t PRI_BR   = 3'd1;
  localparam pri_t PRI_JMP  = 3'd2;
  localparam pri_t PRI_JR   = 3'd3;
  localparam pri_t PRI_ERET = 3'd4;
  localparam pri_t PRI_EXC  = 3'd5;

  typedef struct packed {
    logic            vld;
    pri_t            pri;
    logic [XLEN-1:0] addr;
  } pend_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/npc_ctrl_if.sv
// Decode/CP0 side to next-PC sequencer bus; addr_err exists only with ALIGN_CHECK_EN.
interface npc_ctrl_if;
  logic [31:0] pc_cur;
  logic        br_taken;
  logic [15:0] br_off;
  logic        jmp;
  logic [25:0] jmp_idx;
  logic        jr;
  logic [31:0] jr_addr;
  logic        eret;
  logic [31:0] epc;
  logic        exc_req;
  logic        stall_req;
  logic [31:0] npc;
  logic        pc_ctr;
  logic        pc_ena;
  logic [31:0] link_addr;
  logic        stall_timeout;
`ifdef ALIGN_CHECK_EN
  logic        addr_err;

  modport master (
    output pc_cur, br_taken, br_off, jmp, jmp_idx, jr, jr_addr, eret, epc, exc_req, stall_req,
    input  npc, pc_ctr, pc_ena, link_addr, stall_timeout, addr_err
  );
  modport slave (
    input  pc_cur, br_taken, br_off, jmp, jmp_idx, jr, jr_addr, eret, epc, exc_req, stall_req,
    output npc, pc_ctr, pc_ena, link_addr, stall_timeout, addr_err
  );
`else
  modport master (
    output pc_cur, br_taken, br_off, jmp, jmp_idx, jr, jr_addr, eret, epc, exc_req, stall_req,
    input  npc, pc_ctr, pc_ena, link_addr, stall_timeout
  );
  modport slave (
    input  pc_cur, br_taken, br_off, jmp, jmp_idx, jr, jr_addr, eret, epc, exc_req, stall_req,
    output npc, pc_ctr, pc_ena, link_addr, stall_timeout
  );
`endif
endinterface

// File: rtl/npc_target_calc.sv
// Combinational sequential/branch/jump target generation; link address equals the sequential target.
module npc_target_calc
  import npc_pkg::*;
(
  input  logic [XLEN-1:0] i_pc_cur,
  input  logic [15:0]     i_br_off,
  input  logic [25:0]     i_jmp_idx,
  output logic [XLEN-1:0] o_seq,
  output logic [XLEN-1:0] o_branch,
  output logic [XLEN-1:0] o_jump,
  output logic [XLEN-1:0] o_link
);

  logic [XLEN-1:0] w_br_disp;

  assign o_seq     = i_pc_cur + XLEN'(4);
  assign w_br_disp = {{14{i_br_off[15]}}, i_br_off, 2'b00};
  assign o_branch  = o_seq + w_br_disp;
  assign o_jump    = {o_seq[31:28], i_jmp_idx, 2'b00};
  assign o_link    = o_seq;

endmodule

// File: rtl/npc_ctrl.sv
// Next-PC sequencer: selects the fetch target, holds redirects across stalls, drives the PC register.
// Define ALIGN_CHECK_EN to trap misaligned jr/eret targets to EXC_VECTOR with an addr_err pulse.
module npc_ctrl
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DFLT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DFLT,
  parameter int unsigned STALL_MAX  = 64
) (
  input  logic       clk,
  input  logic       rst,
  npc_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] STALL_MAX_C = CNT_W'(STALL_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;

  logic [XLEN-1:0]  w_seq, w_branch, w_jump, w_link;
  pri_t             w_sel_pri;
  logic [XLEN-1:0]  w_sel_addr;
  state_t           r_state, w_state_nxt;
  logic [XLEN-1:0]  r_npc, w_npc_nxt;
  logic             r_pc_ena, w_pc_ena_nxt;
  logic             r_pc_ctr;
  logic             r_tmo, w_tmo_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  pend_t            r_pend, w_pend_nxt;
`ifdef ALIGN_CHECK_EN
  logic             w_sel_mis;
  logic             r_addr_err, w_addr_err_nxt;
`endif

  npc_target_calc u_target (
    .i_pc_cur  (bus.pc_cur),
    .i_br_off  (bus.br_off),
    .i_jmp_idx (bus.jmp_idx),
    .o_seq     (w_seq),
    .o_branch  (w_branch),
    .o_jump    (w_jump),
    .o_link    (w_link)
  );

  // Fixed-priority redirect select
  always_comb begin
    w_sel_pri  = PRI_NONE;
    w_sel_addr = w_seq;
`ifdef ALIGN_CHECK_EN
    w_sel_mis  = 1'b0;
`endif
    if (bus.exc_req) begin
      w_sel_pri  = PRI_EXC;
      w_sel_addr = EXC_VECTOR;
    end else if (bus.eret) begin
      w_sel_pri  = PRI_ERET;
      w_sel_addr = bus.epc;
    end else if (bus.jr) begin
      w_sel_pri  = PRI_JR;
      w_sel_addr = bus.jr_addr;
    end else if (bus.jmp) begin
      w_sel_pri  = PRI_JMP;
      w_sel_addr = w_jump;
    end else if (bus.br_taken) begin
      w_sel_pri  = PRI_BR;
      w_sel_addr = w_branch;
    end
`ifdef ALIGN_CHECK_EN
    // A bad jr/eret target behaves exactly like an exception request
    if ((w_sel_pri == PRI_ERET || w_sel_pri == PRI_JR) && is_misaligned(w_sel_addr)) begin
      w_sel_mis  = 1'b1;
      w_sel_pri  = PRI_EXC;
      w_sel_addr = EXC_VECTOR;
    end
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_npc_nxt    = r_npc;
    w_pc_ena_nxt = 1'b0;
    w_tmo_nxt    = r_tmo;
    w_cnt_nxt    = r_cnt;
    w_pend_nxt   = r_pend;
`ifdef ALIGN_CHECK_EN
    w_addr_err_nxt = 1'b0;
`endif
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (!bus.stall_req) begin
          w_npc_nxt    = w_sel_addr;
          w_pc_ena_nxt = 1'b1;
`ifdef ALIGN_CHECK_EN
          w_addr_err_nxt = w_sel_mis;
`endif
        end else begin
          w_state_nxt = ST_STALL;
          w_cnt_nxt   = '0;
          if (w_sel_pri != PRI_NONE) begin
            w_pend_nxt = '{vld: 1'b1, pri: w_sel_pri, addr: w_sel_addr};
`ifdef ALIGN_CHECK_EN
            w_addr_err_nxt = w_sel_mis;
`endif
          end
        end
      end
      ST_STALL: begin
        if (bus.stall_req) begin
          w_cnt_nxt = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
          if (w_cnt_nxt > STALL_MAX_C) w_tmo_nxt = 1'b1;
          if (w_sel_pri != PRI_NONE && (!r_pend.vld || w_sel_pri >= r_pend.pri)) begin
            w_pend_nxt = '{vld: 1'b1, pri: w_sel_pri, addr: w_sel_addr};
`ifdef ALIGN_CHECK_EN
            w_addr_err_nxt = w_sel_mis;
`endif
          end
        end else begin
          w_npc_nxt    = r_pend.vld ? r_pend.addr : w_sel_addr;
          w_pc_ena_nxt = 1'b1;
          w_pend_nxt   = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_RUN;
`ifdef ALIGN_CHECK_EN
          w_addr_err_nxt = !r_pend.vld && w_sel_mis;
`endif
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_BOOT;
      r_npc    <= RESET_PC;
      r_pc_ctr <= 1'b1;
      r_pc_ena <= 1'b0;
      r_tmo    <= 1'b0;
      r_cnt    <= '0;
      r_pend   <= '0;
`ifdef ALIGN_CHECK_EN
      r_addr_err <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_npc    <= w_npc_nxt;
      r_pc_ctr <= 1'b1;
      r_pc_ena <= w_pc_ena_nxt;
      r_tmo    <= w_tmo_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pend   <= w_pend_nxt;
`ifdef ALIGN_CHECK_EN
      r_addr_err <= w_addr_err_nxt;
`endif
    end
  end

  assign bus.npc           = r_npc;
  assign bus.pc_ctr        = r_pc_ctr;
  assign bus.pc_ena        = r_pc_ena;
  assign bus.stall_timeout = r_tmo;
  assign bus.link_addr     = w_link;
`ifdef ALIGN_CHECK_EN
  assign bus.addr_err      = r_addr_err;
`endif

endmodule

// File: tb/tb_npc_ctrl.sv
// Self-checking bench for npc_ctrl: vector table for target selection plus stall/reset sequences.
module tb_npc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC  = 32'h0040_0004;
`ifdef ALIGN_CHECK_EN
  localparam logic [31:0] EXP_MIS_JR   = EXC_VEC;
  localparam logic [31:0] EXP_MIS_ERET = EXC_VEC;
`else
  localparam logic [31:0] EXP_MIS_JR   = 32'h0040_1002;
  localparam logic [31:0] EXP_MIS_ERET = 32'h0040_0103;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  npc_ctrl_if bus();

  npc_ctrl #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VEC), .STALL_MAX(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] jra;
    logic        eret;
    logic [31:0] epc;
    logic        exc;
    logic [31:0] exp_npc;
    logic        exp_aerr;
  } vec_t;

  typedef struct {
    logic [31:0] npc;
    logic        ena;
    logic        tmo;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_npc;
  logic        m_tmo;
  int          n_checks = 0;
  int          n_errors = 0;
  vec_t        vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    bus.br_taken  = 1'b0;  bus.br_off  = 16'h0;
    bus.jmp       = 1'b0;  bus.jmp_idx = 26'h0;
    bus.jr        = 1'b0;  bus.jr_addr = 32'h0;
    bus.eret      = 1'b0;  bus.epc     = 32'h0;
    bus.exc_req   = 1'b0;  bus.stall_req = 1'b0;
  endtask

  // Record what the DUT must show after the coming clock edge
  task automatic push(input logic ena, input logic [31:0] npc);
    exp_t e;
    if (ena) m_npc = npc;
    e.npc = m_npc; e.ena = ena; e.tmo = m_tmo;
    sb_q.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".npc"},    bus.npc, e.npc);
      chk({tag, ".pc_ena"}, 32'(bus.pc_ena), 32'(e.ena));
      chk({tag, ".pc_ctr"}, 32'(bus.pc_ctr), 32'd1);
      chk({tag, ".tmo"},    32'(bus.stall_timeout), 32'(e.tmo));
    end
  endtask

  task automatic apply(input vec_t v);
    clear_in();
    bus.pc_cur = v.pc;  bus.br_taken = v.br;  bus.br_off = v.off;
    bus.jmp = v.jmp;    bus.jmp_idx = v.idx;  bus.jr = v.jr;  bus.jr_addr = v.jra;
    bus.eret = v.eret;  bus.epc = v.epc;      bus.exc_req = v.exc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          name        pc            br   off       jmp  idx           jr   jra           eret epc           exc  exp           aerr
    vt[0]  = '{"br_back",   32'h0040_0010, 1'b1, 16'hFFFC, 1'b0, 26'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0040_0004, 1'b0};
    vt[1]  = '{"jmp",       32'h0040_0010, 1'b0, 16'h0,    1'b1, 26'h010_0008, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0040_0020, 1'b0};
    vt[2]  = '{"exc_all",   32'h0040_0010, 1'b1, 16'h0010, 1'b1, 26'h1,        1'b1, 32'h0040_0200, 1'b1, 32'h0040_0100, 1'b1, EXC_VEC,       1'b0};
    vt[3]  = '{"eret_pri",  32'h0040_0010, 1'b1, 16'h0010, 1'b1, 26'h1,        1'b1, 32'h0040_0200, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0100, 1'b0};
    vt[4]  = '{"jr_pri",    32'h0040_0010, 1'b1, 16'h0010, 1'b1, 26'h1,        1'b1, 32'h0040_0200, 1'b0, 32'h0,        1'b0, 32'h0040_0200, 1'b0};
    vt[5]  = '{"jmp_pri",   32'hA000_0000, 1'b1, 16'h0010, 1'b1, 26'h3FF_FFFF, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'hAFFF_FFFC, 1'b0};
    vt[6]  = '{"seq",       32'h0040_0020, 1'b0, 16'h0,    1'b0, 26'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0040_0024, 1'b0};
    vt[7]  = '{"br_wrap",   32'hFFFF_FFF8, 1'b1, 16'h0002, 1'b0, 26'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0004, 1'b0};
    vt[8]  = '{"seq_wrap",  32'hFFFF_FFFC, 1'b0, 16'h0,    1'b0, 26'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0000, 1'b0};
    vt[9]  = '{"jmp_seqhi", 32'h0FFF_FFFC, 1'b0, 16'h0,    1'b1, 26'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h1000_0000, 1'b0};
    vt[10] = '{"br_maxpos", 32'h0040_0000, 1'b1, 16'h7FFF, 1'b0, 26'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0042_0000, 1'b0};
    vt[11] = '{"br_maxneg", 32'h0040_0000, 1'b1, 16'h8000, 1'b0, 26'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h003E_0004, 1'b0};
    vt[12] = '{"jr_mis",    32'h0040_0000, 1'b0, 16'h0,    1'b0, 26'h0,        1'b1, 32'h0040_1002, 1'b0, 32'h0,        1'b0, EXP_MIS_JR,    1'b1};
    vt[13] = '{"after_mis", 32'h0040_0000, 1'b0, 16'h0,    1'b0, 26'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0040_0004, 1'b0};
    vt[14] = '{"eret_mis",  32'h0040_0000, 1'b0, 16'h0,    1'b0, 26'h0,        1'b0, 32'h0,        1'b1, 32'h0040_0103, 1'b0, EXP_MIS_ERET,  1'b1};
    vt[15] = '{"jr_align",  32'h0040_0000, 1'b0, 16'h0,    1'b0, 26'h0,        1'b1, 32'h0040_0300, 1'b0, 32'h0,        1'b0, 32'h0040_0300, 1'b0};

    clear_in();
    bus.pc_cur = RESET_PC;
    m_tmo = 1'b0;
    m_npc = RESET_PC;

    // Reset and boot
    rst = 1'b1;
    push(1'b0, 32'h0); tick("reset0");
    push(1'b0, 32'h0); tick("reset1");
    rst = 1'b0;
    push(1'b0, 32'h0); tick("boot");
    push(1'b1, 32'h0040_0004); tick("first_run");

    // Target selection table
    foreach (vt[i]) begin
      apply(vt[i]);
      @(negedge clk);
      chk({vt[i].name, ".link"}, bus.link_addr, vt[i].pc + 32'd4);
      push(1'b1, vt[i].exp_npc);
      tick(vt[i].name);
`ifdef ALIGN_CHECK_EN
      chk({vt[i].name, ".addr_err"}, 32'(bus.addr_err), 32'(vt[i].exp_aerr));
`endif
    end

    // Redirect arriving in stall cycle 2 is held until the stall ends
    clear_in(); bus.pc_cur = 32'h0040_0200;
    for (int c = 1; c <= 5; c++) begin
      bus.stall_req = 1'b1;
      bus.jr = (c == 2); bus.jr_addr = 32'h0040_1000;
      push(1'b0, 32'h0); tick("stall_hold");
    end
    clear_in(); push(1'b1, 32'h0040_1000); tick("stall_release");

    // Exception together with stall_req is pended; a later branch cannot displace it
    bus.stall_req = 1'b1; bus.exc_req = 1'b1; push(1'b0, 32'h0); tick("exc_pend");
    bus.exc_req = 1'b0; bus.br_taken = 1'b1; bus.br_off = 16'h0004;
    push(1'b0, 32'h0); tick("exc_keep");
    clear_in(); bus.pc_cur = 32'h0040_0040; push(1'b1, EXC_VEC); tick("exc_release");

    // Lower priority ignored, equal priority overwrites
    bus.stall_req = 1'b1; push(1'b0, 32'h0); tick("pri_s0");
    bus.eret = 1'b1; bus.epc = 32'h0040_0500; push(1'b0, 32'h0); tick("pri_s1");
    bus.eret = 1'b0; bus.jr = 1'b1; bus.jr_addr = 32'h0040_0600; push(1'b0, 32'h0); tick("pri_s2");
    bus.jr = 1'b0; bus.eret = 1'b1; bus.epc = 32'h0040_0700; push(1'b0, 32'h0); tick("pri_s3");
    clear_in(); push(1'b1, 32'h0040_0700); tick("pri_release");

    // No pending entry: the release cycle uses its own selected target
    bus.pc_cur = 32'h0040_0000; bus.stall_req = 1'b1; push(1'b0, 32'h0); tick("nopend_s");
    clear_in(); bus.jmp = 1'b1; bus.jmp_idx = 26'h010_0010;
    push(1'b1, 32'h0040_0040); tick("nopend_release");

    // Pending jr from RUN is overwritten by exception in STALL
    clear_in(); bus.stall_req = 1'b1; bus.jr = 1'b1; bus.jr_addr = 32'h0040_0800;
    push(1'b0, 32'h0); tick("jr_then_exc0");
    bus.jr = 1'b0; bus.exc_req = 1'b1; push(1'b0, 32'h0); tick("jr_then_exc1");
    clear_in(); push(1'b1, EXC_VEC); tick("jr_then_exc_rel");

    // Timeout: asserts after STALL_MAX+2 stall cycles and stays until reset
    clear_in(); bus.pc_cur = 32'h0040_0000;
    for (int c = 1; c <= 66; c++) begin
      bus.stall_req = 1'b1;
      if (c == 66) m_tmo = 1'b1;
      push(1'b0, 32'h0); tick("tmo_stall");
    end
    clear_in();
    for (int c = 0; c < 3; c++) begin
      push(1'b1, 32'h0040_0004); tick("tmo_sticky");
    end

    // Reset mid-stall discards the pending redirect
    bus.stall_req = 1'b1; bus.jr = 1'b1; bus.jr_addr = 32'h0040_0ABC;
    push(1'b0, 32'h0); tick("rst_pend");
    rst = 1'b1; m_tmo = 1'b0; m_npc = RESET_PC;
    push(1'b0, 32'h0); tick("rst_mid");
    rst = 1'b0; bus.stall_req = 1'b0;
    push(1'b0, 32'h0); tick("rst_boot_ignores");
    clear_in(); bus.stall_req = 1'b1; push(1'b0, 32'h0); tick("rst_stall");
    clear_in(); push(1'b1, 32'h0040_0004); tick("rst_no_stale");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
